execute_writeback_history: RTL and testbench

- Two-deep writeback history register that sits directly downstream of the execute stage.
- Captures each retiring instruction's GR, SPR and FRCR writeback and presents it as the "current" writeback set.
- On the next advance, the current set moves to the "previous" writeback set.
- Both sets feed the execute forwarding network and the register-file write port.
- Also keeps a sticky latest-SPR value so the forwarding SPR path always has a defined fallback.

---
 rtl/execute_writeback_history_pkg.sv | 37 +++
 rtl/execute_writeback_history_if.sv | 66 ++++++
 rtl/execute_writeback_history_slot.sv | 23 ++
 rtl/execute_writeback_history.sv | 92 +++++++++
 tb/tb_execute_writeback_history.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/execute_writeback_history_pkg.sv
// Shared writeback record types for the execute writeback history.
// Used by the history top, its slot register and the interface.
package execute_wb_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        sysreg;
  } wb_gr_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } wb_spr_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } wb_frcr_t;

  typedef struct packed {
    wb_gr_t   gr;
    wb_spr_t  spr;
    wb_frcr_t frcr;
  } wb_set_t;

  function automatic wb_set_t wb_clear_valid(input wb_set_t s);
    wb_set_t r;
    r            = s;
    r.gr.valid   = 1'b0;
    r.spr.valid  = 1'b0;
    r.frcr.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/execute_writeback_history_if.sv
// Execute-to-writeback history bus; slave = history block, master = driver/consumer.
// Optional retire counter port present when MIST32_WB_HISTORY_COUNT_EN is defined.
interface execute_writeback_history_if;
  logic        iFLUSH;
  logic        iSTALL;
  logic        iEXE_VALID;
  logic        iEXE_GR_VALID;
  logic [31:0] iEXE_GR_DATA;
  logic [4:0]  iEXE_GR_DEST;
  logic        iEXE_GR_DEST_SYSREG;
  logic        iEXE_SPR_VALID;
  logic [31:0] iEXE_SPR_DATA;
  logic        iEXE_FRCR_VALID;
  logic [63:0] iEXE_FRCR_DATA;

  logic        oWB_GR_VALID;
  logic [31:0] oWB_GR_DATA;
  logic [4:0]  oWB_GR_DEST;
  logic        oWB_GR_DEST_SYSREG;
  logic        oWB_SPR_VALID;
  logic [31:0] oWB_SPR_DATA;
  logic        oWB_FRCR_VALID;
  logic [63:0] oWB_FRCR_DATA;

  logic        oPREV_WB_GR_VALID;
  logic [31:0] oPREV_WB_GR_DATA;
  logic [4:0]  oPREV_WB_GR_DEST;
  logic        oPREV_WB_GR_DEST_SYSREG;
  logic        oPREV_WB_SPR_VALID;
  logic [31:0] oPREV_WB_SPR_DATA;
  logic        oPREV_WB_FRCR_VALID;
  logic [63:0] oPREV_WB_FRCR_DATA;

  logic [31:0] oSPR_LATEST;
`ifdef MIST32_WB_HISTORY_COUNT_EN
  logic [31:0] oWB_RETIRE_COUNT;
`endif

  modport slave (
    input  iFLUSH, iSTALL, iEXE_VALID,
    input  iEXE_GR_VALID, iEXE_GR_DATA, iEXE_GR_DEST, iEXE_GR_DEST_SYSREG,
    input  iEXE_SPR_VALID, iEXE_SPR_DATA, iEXE_FRCR_VALID, iEXE_FRCR_DATA,
    output oWB_GR_VALID, oWB_GR_DATA, oWB_GR_DEST, oWB_GR_DEST_SYSREG,
    output oWB_SPR_VALID, oWB_SPR_DATA, oWB_FRCR_VALID, oWB_FRCR_DATA,
    output oPREV_WB_GR_VALID, oPREV_WB_GR_DATA, oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG,
    output oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA, oPREV_WB_FRCR_VALID, oPREV_WB_FRCR_DATA,
`ifdef MIST32_WB_HISTORY_COUNT_EN
    output oWB_RETIRE_COUNT,
`endif
    output oSPR_LATEST
  );

  modport master (
    output iFLUSH, iSTALL, iEXE_VALID,
    output iEXE_GR_VALID, iEXE_GR_DATA, iEXE_GR_DEST, iEXE_GR_DEST_SYSREG,
    output iEXE_SPR_VALID, iEXE_SPR_DATA, iEXE_FRCR_VALID, iEXE_FRCR_DATA,
    input  oWB_GR_VALID, oWB_GR_DATA, oWB_GR_DEST, oWB_GR_DEST_SYSREG,
    input  oWB_SPR_VALID, oWB_SPR_DATA, oWB_FRCR_VALID, oWB_FRCR_DATA,
    input  oPREV_WB_GR_VALID, oPREV_WB_GR_DATA, oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG,
    input  oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA, oPREV_WB_FRCR_VALID, oPREV_WB_FRCR_DATA,
`ifdef MIST32_WB_HISTORY_COUNT_EN
    input  oWB_RETIRE_COUNT,
`endif
    input  oSPR_LATEST
  );
endinterface

// File: rtl/execute_writeback_history_slot.sv
// One writeback history slot: a wb_set_t register with load, clear-valid and hold.
// Clearing valids keeps the data fields so a flush never disturbs payloads.
module execute_wb_slot
  import execute_wb_pkg::*;
(
  input  logic    iCLOCK,
  input  logic    inRESET,
  input  logic    load,
  input  logic    clear_valid,
  input  wb_set_t d,
  output wb_set_t q
);

  always_ff @(posedge iCLOCK) begin
    if (!inRESET)
      q <= '0;
    else if (clear_valid)
      q <= wb_clear_valid(q);
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/execute_writeback_history.sv
// Two-deep execute writeback history (current/previous) plus sticky latest SPR.
// Define MIST32_WB_HISTORY_COUNT_EN to add the oWB_RETIRE_COUNT retire counter.
module execute_writeback_history
  import execute_wb_pkg::*;
#(
  parameter logic [31:0] SPR_RESET = 32'h0000_0000
)(
  input  logic                           iCLOCK,
  input  logic                           inRESET,
  execute_writeback_history_if.slave     wb
);

  wb_set_t exe_set;
  wb_set_t cur_q;
  wb_set_t prev_q;
  logic    advance;
  logic [31:0] spr_latest_q;

  assign advance = !wb.iFLUSH && !wb.iSTALL;

  // Payloads are captured unconditionally; only the valids are gated by retire.
  always_comb begin
    exe_set             = '0;
    exe_set.gr.valid    = wb.iEXE_VALID & wb.iEXE_GR_VALID;
    exe_set.gr.data     = wb.iEXE_GR_DATA;
    exe_set.gr.dest     = wb.iEXE_GR_DEST;
    exe_set.gr.sysreg   = wb.iEXE_GR_DEST_SYSREG;
    exe_set.spr.valid   = wb.iEXE_VALID & wb.iEXE_SPR_VALID;
    exe_set.spr.data    = wb.iEXE_SPR_DATA;
    exe_set.frcr.valid  = wb.iEXE_VALID & wb.iEXE_FRCR_VALID;
    exe_set.frcr.data   = wb.iEXE_FRCR_DATA;
  end

  execute_wb_slot u_cur (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .load        (advance),
    .clear_valid (wb.iFLUSH),
    .d           (exe_set),
    .q           (cur_q)
  );

  execute_wb_slot u_prev (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .load        (advance),
    .clear_valid (wb.iFLUSH),
    .d           (cur_q),
    .q           (prev_q)
  );

  always_ff @(posedge iCLOCK) begin
    if (!inRESET)
      spr_latest_q <= SPR_RESET;
    else if (advance && exe_set.spr.valid)
      spr_latest_q <= wb.iEXE_SPR_DATA;
  end

`ifdef MIST32_WB_HISTORY_COUNT_EN
  logic [31:0] retire_count_q;

  always_ff @(posedge iCLOCK) begin
    if (!inRESET)
      retire_count_q <= '0;
    else if (advance && wb.iEXE_VALID)
      retire_count_q <= retire_count_q + 32'd1;
  end

  assign wb.oWB_RETIRE_COUNT = retire_count_q;
`endif

  assign wb.oWB_GR_VALID            = cur_q.gr.valid;
  assign wb.oWB_GR_DATA             = cur_q.gr.data;
  assign wb.oWB_GR_DEST             = cur_q.gr.dest;
  assign wb.oWB_GR_DEST_SYSREG      = cur_q.gr.sysreg;
  assign wb.oWB_SPR_VALID           = cur_q.spr.valid;
  assign wb.oWB_SPR_DATA            = cur_q.spr.data;
  assign wb.oWB_FRCR_VALID          = cur_q.frcr.valid;
  assign wb.oWB_FRCR_DATA           = cur_q.frcr.data;

  assign wb.oPREV_WB_GR_VALID       = prev_q.gr.valid;
  assign wb.oPREV_WB_GR_DATA        = prev_q.gr.data;
  assign wb.oPREV_WB_GR_DEST        = prev_q.gr.dest;
  assign wb.oPREV_WB_GR_DEST_SYSREG = prev_q.gr.sysreg;
  assign wb.oPREV_WB_SPR_VALID      = prev_q.spr.valid;
  assign wb.oPREV_WB_SPR_DATA       = prev_q.spr.data;
  assign wb.oPREV_WB_FRCR_VALID     = prev_q.frcr.valid;
  assign wb.oPREV_WB_FRCR_DATA      = prev_q.frcr.data;

  assign wb.oSPR_LATEST             = spr_latest_q;

endmodule

// File: tb/tb_execute_writeback_history.sv
// Scoreboard bench for execute_writeback_history: directed scenarios then random traffic.
// Reference keeps history as a two-entry list of retired records.
module tb_execute_writeback_history;
  import execute_wb_pkg::*;

  localparam logic [31:0] SPR_RST = 32'h5A5A_0001;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  execute_writeback_history_if wbif();

  execute_writeback_history #(.SPR_RESET(SPR_RST)) dut (
    .iCLOCK  (clk),
    .inRESET (rst_b),
    .wb      (wbif)
  );

  typedef struct {
    wb_set_t     cur;
    wb_set_t     prev;
    logic [31:0] latest;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  wb_set_t     hist[2];   // [0] = most recent advance, [1] = the one before
  logic [31:0] m_latest;
  logic [31:0] m_cnt;
  int          checks_total  = 0;
  int          checks_passed = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
    checks_total++;
    if (act === expv) checks_passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
  endtask

  task automatic cycle(input bit rst, input bit flush, input bit stall, input bit v,
                       input bit grv, input logic [31:0] grd, input logic [4:0] dest, input bit sys,
                       input bit sprv, input logic [31:0] sprd,
                       input bit frcrv, input logic [63:0] frcrd);
    wb_set_t rec;
    exp_t    e;
    @(negedge clk);
    rst_b                    = rst;
    wbif.iFLUSH              = flush;
    wbif.iSTALL              = stall;
    wbif.iEXE_VALID          = v;
    wbif.iEXE_GR_VALID       = grv;
    wbif.iEXE_GR_DATA        = grd;
    wbif.iEXE_GR_DEST        = dest;
    wbif.iEXE_GR_DEST_SYSREG = sys;
    wbif.iEXE_SPR_VALID      = sprv;
    wbif.iEXE_SPR_DATA       = sprd;
    wbif.iEXE_FRCR_VALID     = frcrv;
    wbif.iEXE_FRCR_DATA      = frcrd;

    rec.gr   = '{valid: v && grv,   data: grd,   dest: dest, sysreg: sys};
    rec.spr  = '{valid: v && sprv,  data: sprd};
    rec.frcr = '{valid: v && frcrv, data: frcrd};
    if (!rst) begin
      hist[0] = '0; hist[1] = '0; m_latest = SPR_RST; m_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        hist[i].gr.valid = 0; hist[i].spr.valid = 0; hist[i].frcr.valid = 0;
      end
    end else if (!stall) begin
      hist[1] = hist[0];
      hist[0] = rec;
      if (v && sprv) m_latest = sprd;
      if (v) m_cnt = m_cnt + 1;
    end
    e.cur = hist[0]; e.prev = hist[1]; e.latest = m_latest; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t    e;
    wb_set_t a_cur, a_prev;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_cur.gr   = '{wbif.oWB_GR_VALID, wbif.oWB_GR_DATA, wbif.oWB_GR_DEST, wbif.oWB_GR_DEST_SYSREG};
        a_cur.spr  = '{wbif.oWB_SPR_VALID, wbif.oWB_SPR_DATA};
        a_cur.frcr = '{wbif.oWB_FRCR_VALID, wbif.oWB_FRCR_DATA};
        a_prev.gr  = '{wbif.oPREV_WB_GR_VALID, wbif.oPREV_WB_GR_DATA, wbif.oPREV_WB_GR_DEST,
                       wbif.oPREV_WB_GR_DEST_SYSREG};
        a_prev.spr = '{wbif.oPREV_WB_SPR_VALID, wbif.oPREV_WB_SPR_DATA};
        a_prev.frcr = '{wbif.oPREV_WB_FRCR_VALID, wbif.oPREV_WB_FRCR_DATA};
        chk("current_set",  160'(a_cur),  160'(e.cur));
        chk("previous_set", 160'(a_prev), 160'(e.prev));
        chk("spr_latest",   160'(wbif.oSPR_LATEST), 160'(e.latest));
`ifdef MIST32_WB_HISTORY_COUNT_EN
        chk("retire_count", 160'(wbif.oWB_RETIRE_COUNT), 160'(e.cnt));
`endif
      end
    end
  end

  initial begin : driver
    rst_b = 1'b0;
    wbif.iFLUSH = 0; wbif.iSTALL = 0; wbif.iEXE_VALID = 0;
    wbif.iEXE_GR_VALID = 0; wbif.iEXE_GR_DATA = 0; wbif.iEXE_GR_DEST = 0;
    wbif.iEXE_GR_DEST_SYSREG = 0; wbif.iEXE_SPR_VALID = 0; wbif.iEXE_SPR_DATA = 0;
    wbif.iEXE_FRCR_VALID = 0; wbif.iEXE_FRCR_DATA = 0;

    // reset held with a retiring instruction driven
    cycle(0, 0, 0, 1, 1, 32'h9999, 5'd1, 0, 1, 32'h77, 1, 64'h5);
    cycle(0, 0, 0, 1, 1, 32'h9999, 5'd1, 0, 1, 32'h77, 1, 64'h5);
    idle(1);

    // shift r3 -> r4
    cycle(1, 0, 0, 1, 1, 32'h1111, 5'd3, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 32'h2222, 5'd4, 0, 0, 0, 0, 0);
    // bubble after r5
    cycle(1, 0, 0, 1, 1, 32'hAAAA, 5'd5, 0, 0, 0, 0, 0);
    idle(2);

    // stall 3 cycles while r8 is presented, then r8 captured
    cycle(1, 0, 0, 1, 1, 32'h6666, 5'd6, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 32'h7777, 5'd7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 1, 32'h8888, 5'd8, 0, 1, 32'hDEAD, 0, 0);
    cycle(1, 0, 0, 1, 1, 32'h8888, 5'd8, 0, 1, 32'h0BEE, 0, 0);

    // flush wins over stall
    cycle(1, 1, 1, 1, 1, 32'h3333, 5'd9, 0, 1, 32'h1234, 1, 64'h9);
    idle(1);

    // SPR + FRCR together, then age out
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_F000, 1, 64'h1_0000_0002);
    idle(3);

    // sysreg GR write leaves latest SPR alone
    cycle(1, 0, 0, 1, 1, 32'hCAFE, 5'd2, 1, 0, 32'hBAD0, 0, 0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) != 0), ($urandom_range(15) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) != 0), $urandom_range(1) == 1, $urandom, 5'($urandom),
            $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom,
            $urandom_range(1) == 1, {$urandom, $urandom});
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
